// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo-N up/down counter with step, saturate, prescaler and sticky flags
module param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int STEP_W    = 4,
  parameter int PRESCALE  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_up_down,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_sat_mode,
  input  logic              i_clr_flags,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_bnd_pulse,
  output logic              o_ovf,
  output logic              o_unf
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0] MAXX = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VALUE);
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_bnd, r_ovf, r_unf;
  logic             w_tick, w_ovf_ev, w_unf_ev, w_bnd;
  logic [WIDTH:0]   w_cnt, w_stepx, w_s, w_sum;
  logic [WIDTH-1:0] w_next, w_load;
  always_comb begin
    w_tick   = i_en && r_presc == PW'(PRESCALE-1);
    w_cnt    = {1'b0, r_count};
    w_stepx  = (WIDTH+1)'(i_step);
    w_s      = w_stepx > MAXX ? MAXX : w_stepx;
    w_sum    = w_cnt + w_s;
    w_ovf_ev = i_up_down && w_sum > MAXX;
    w_unf_ev = !i_up_down && w_s > w_cnt;
    // Wrap folds the excess back into 0..MAX_VALUE; saturate pins to the bound crossed
    w_next   = i_up_down
             ? (w_ovf_ev ? (i_sat_mode ? MAXW : WIDTH'(w_sum - MAXX - 1'b1)) : WIDTH'(w_sum))
             : (w_unf_ev ? (i_sat_mode ? '0 : WIDTH'(w_cnt + MAXX + 1'b1 - w_s)) : WIDTH'(w_cnt - w_s));
    w_bnd    = w_s != '0 && (w_ovf_ev || w_unf_ev || w_next == (i_up_down ? MAXW : '0));
    w_load   = {1'b0, i_load_val} > MAXX ? MAXW : i_load_val;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_bnd   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= i_load ? w_load : w_tick ? w_next : r_count;
      r_presc <= i_load ? '0 : i_en ? (w_tick ? '0 : r_presc + 1'b1) : r_presc;
      r_bnd   <= !i_load && w_tick && w_bnd;
      r_ovf   <= (r_ovf && !i_clr_flags) || (!i_load && w_tick && w_ovf_ev);
      r_unf   <= (r_unf && !i_clr_flags) || (!i_load && w_tick && w_unf_ev);
    end
  end
  assign o_count     = r_count;
  assign o_bnd_pulse = r_bnd;
  assign o_ovf       = r_ovf;
  assign o_unf       = r_unf;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed vector table for WIDTH=4, MAX=9 with PRESCALE 1 and 3
module tb_param_updown_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, load, up_down, sat_mode, clr_flags;
  logic [3:0] load_val, step;
  logic [3:0] a_count, b_count;
  logic       a_bnd, a_ovf, a_unf, b_bnd, b_ovf, b_unf;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .STEP_W(4), .PRESCALE(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_load_val(load_val),
    .i_up_down(up_down), .i_step(step), .i_sat_mode(sat_mode), .i_clr_flags(clr_flags),
    .o_count(a_count), .o_bnd_pulse(a_bnd), .o_ovf(a_ovf), .o_unf(a_unf));

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .STEP_W(4), .PRESCALE(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_load_val(load_val),
    .i_up_down(up_down), .i_step(step), .i_sat_mode(sat_mode), .i_clr_flags(clr_flags),
    .o_count(b_count), .o_bnd_pulse(b_bnd), .o_ovf(b_ovf), .o_unf(b_unf));

  typedef struct {
    logic       sel;
    logic       rst_n, en, load;
    logic [3:0] lv;
    logic       up;
    logic [3:0] st;
    logic       sat, clr;
    logic [3:0] cnt;
    logic       bnd, ovf, unf;
  } vec_t;

  vec_t v[$];

  function automatic void add(input logic sel, input logic r, input logic e, input logic ld,
                              input logic [3:0] lv, input logic up, input logic [3:0] st,
                              input logic sat, input logic clr, input logic [3:0] cnt,
                              input logic bnd, input logic ovf, input logic unf);
    vec_t x;
    x.sel = sel; x.rst_n = r; x.en = e; x.load = ld; x.lv = lv; x.up = up; x.st = st;
    x.sat = sat; x.clr = clr; x.cnt = cnt; x.bnd = bnd; x.ovf = ovf; x.unf = unf;
    v.push_back(x);
  endfunction

  task automatic chk(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, i, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    @(negedge clk);
    rst_n = x.rst_n; en = x.en; load = x.load; load_val = x.lv;
    up_down = x.up; step = x.st; sat_mode = x.sat; clr_flags = x.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x, input int i);
    drive(x);
    if (x.sel) begin
      chk("b_count", i, b_count, x.cnt);
      chk("b_bnd", i, {3'b0, b_bnd}, {3'b0, x.bnd});
      chk("b_ovf", i, {3'b0, b_ovf}, {3'b0, x.ovf});
      chk("b_unf", i, {3'b0, b_unf}, {3'b0, x.unf});
    end else begin
      chk("a_count", i, a_count, x.cnt);
      chk("a_bnd", i, {3'b0, a_bnd}, {3'b0, x.bnd});
      chk("a_ovf", i, {3'b0, a_ovf}, {3'b0, x.ovf});
      chk("a_unf", i, {3'b0, a_unf}, {3'b0, x.unf});
    end
  endtask

  initial begin
    vec_t h;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    up_down = 1'b1; step = 4'd1; sat_mode = 1'b0; clr_flags = 1'b0;
    // PRESCALE=1 unit: wrap up, wrap down, saturate, load, flags
    add(0, 0,0,0,0, 1,1,0,0, 0,0,0,0);
    for (int k = 1; k <= 9; k++) add(0, 1,1,0,0, 1,1,0,0, 4'(k), k == 9, 0, 0);
    add(0, 1,1,0,0, 1,1,0,0, 0,1,1,0);
    add(0, 1,1,0,0, 1,1,0,0, 1,0,1,0);
    add(0, 1,1,0,0, 1,1,0,0, 2,0,1,0);
    add(0, 1,0,0,0, 1,1,0,1, 2,0,0,0);
    add(0, 1,0,1,0, 1,1,0,0, 0,0,0,0);
    add(0, 1,1,0,0, 0,3,0,0, 7,1,0,1);
    add(0, 1,1,0,0, 0,3,0,0, 4,0,0,1);
    add(0, 1,1,0,0, 0,3,0,0, 1,0,0,1);
    add(0, 1,1,0,0, 0,3,0,0, 8,1,0,1);
    add(0, 1,0,1,6, 0,3,0,0, 6,0,0,1);
    for (int k = 0; k < 3; k++) add(0, 1,1,0,0, 1,4,1,0, 9,1,1,1);
    add(0, 1,0,1,15, 1,4,1,0, 9,0,1,1);
    add(0, 1,0,0,0, 1,1,0,1, 9,0,0,0);
    add(0, 1,1,1,3, 1,1,0,0, 3,0,0,0);
    add(0, 1,0,1,9, 1,1,0,0, 9,0,0,0);
    add(0, 1,1,0,0, 1,2,0,1, 1,1,1,0);
    add(0, 1,1,0,0, 1,0,0,0, 1,0,1,0);
    add(0, 1,1,0,0, 0,1,0,0, 0,1,1,0);
    add(0, 1,1,0,0, 0,2,1,0, 0,1,1,1);
    add(0, 1,0,1,5, 1,15,0,0, 5,0,1,1);
    add(0, 1,1,0,0, 1,15,0,0, 4,1,1,1);
    add(0, 0,1,0,0, 1,1,0,0, 0,0,0,0);
    add(0, 1,0,0,0, 1,1,0,0, 0,0,0,0);
    // PRESCALE=3 unit: en gating and load restarting the prescaler
    add(1, 0,0,0,0, 1,1,0,0, 0,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 0,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 0,0,0,0);
    add(1, 1,0,0,0, 1,1,0,0, 0,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 1,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 1,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 1,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 2,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 2,0,0,0);
    add(1, 1,1,1,5, 1,1,0,0, 5,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 5,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 5,0,0,0);
    add(1, 1,1,0,0, 1,1,0,0, 6,0,0,0);
    foreach (v[i]) apply(v[i], i);
    // Reset in the middle of a prescale period must restart the 3-cycle spacing
    h = v[v.size()-1];
    h.load = 1'b0; h.en = 1'b1; h.rst_n = 1'b1;
    drive(h);
    drive(h);
    chk("b_pre_before_rst", 100, b_count, 4'd6);
    h.rst_n = 1'b0;
    drive(h);
    chk("b_rst_count", 101, b_count, 4'd0);
    chk("b_rst_ovf", 101, {3'b0, b_ovf}, 4'd0);
    h.rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(h);
      chk("b_after_rst", 102 + k, b_count, k == 2 ? 4'd1 : 4'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
